// File: rtl/fifo_sync_ctl_pkg.sv
// fifo_sync_ctl_pkg: width helpers and parameter checks shared by the FIFO and its users
package fifo_sync_ctl_pkg;

    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int fifo_lvl_w(input int depth);
        return fifo_ptr_w(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_sync_ctl_ram.sv
// fifo_sync_ctl_ram: WIDTH x DEPTH storage, synchronous write, asynchronous read, no reset
module fifo_sync_ctl_ram
    import fifo_sync_ctl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = fifo_ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem [DEPTH];

    // write port; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/fifo_sync_ctl.sv
// fifo_sync_ctl: synchronous FIFO with FWFT/registered read, thresholds, flush and sticky error flags
module fifo_sync_ctl
    import fifo_sync_ctl_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 16,
    parameter int FWFT         = 0,
    parameter int AFULL_LEVEL  = 12,
    parameter int AEMPTY_LEVEL = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush_i,
    input  logic                          wr_en_i,
    input  logic [WIDTH-1:0]              wr_data_i,
    output logic                          full_o,
    output logic                          almost_full_o,
    input  logic                          rd_en_i,
    output logic [WIDTH-1:0]              rd_data_o,
    output logic                          rd_valid_o,
    output logic                          empty_o,
    output logic                          almost_empty_o,
    output logic [fifo_lvl_w(DEPTH)-1:0]  level_o,
    output logic [fifo_lvl_w(DEPTH)-1:0]  free_o,
    output logic                          ovf_o,
    output logic                          udf_o,
    input  logic                          clr_err_i
);
    localparam int PW = fifo_ptr_w(DEPTH);
    localparam int LW = fifo_lvl_w(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AFULL_LEVEL);
    localparam logic [LW-1:0] AE_L    = LW'(AEMPTY_LEVEL);

    if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
        $error("fifo_sync_ctl: DEPTH must be a power of two >= 2");
    end
    if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_af
        $error("fifo_sync_ctl: AFULL_LEVEL out of range");
    end
    if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("fifo_sync_ctl: AEMPTY_LEVEL out of range");
    end

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d, ram_rdata;
    logic             rd_valid_q, rd_valid_d, ovf_q, ovf_d, udf_q, udf_d;
    logic             empty, full, rd_acc, wr_acc, do_rd, do_wr;

    fifo_sync_ctl_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PW)) u_ram (
        .clk     (clk),
        .we_i    (do_wr),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    // accept logic; flush suppresses both sides and the error sets of that cycle
    always_comb begin
        empty      = level_q == '0;
        full       = level_q == DEPTH_L;
        rd_acc     = rd_en_i & ~empty;
        wr_acc     = wr_en_i & (~full | rd_acc);
        do_rd      = rd_acc & ~flush_i;
        do_wr      = wr_acc & ~flush_i;
        wr_ptr_d   = flush_i ? '0 : wr_ptr_q + PW'(do_wr);
        rd_ptr_d   = flush_i ? '0 : rd_ptr_q + PW'(do_rd);
        level_d    = flush_i ? '0 : level_q + LW'(do_wr) - LW'(do_rd);
        rd_valid_d = do_rd;
        rd_data_d  = do_rd ? ram_rdata : rd_data_q;
        ovf_d      = (wr_en_i & ~wr_acc & ~flush_i) | (ovf_q & ~clr_err_i);
        udf_d      = (rd_en_i & empty & ~flush_i) | (udf_q & ~clr_err_i);
    end

    // state registers; memory is not part of the reset domain
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = level_q >= AF_L;
    assign almost_empty_o = level_q <= AE_L;
    assign level_o        = level_q;
    assign free_o         = DEPTH_L - level_q;
    assign ovf_o          = ovf_q;
    assign udf_o          = udf_q;
    assign rd_data_o      = (FWFT != 0) ? ram_rdata : rd_data_q;
    assign rd_valid_o     = (FWFT != 0) ? ~empty : rd_valid_q;
endmodule
